// File: rtl/vga_pkg.sv
// Shared VGA timing and frame-buffer geometry for the display datapath.
// Video RAM words hold PIX_PER_WORD packed pixels, with the LSB pixel first.
package vga_pkg;
    localparam int H_ACTIVE     = 640;
    localparam int V_ACTIVE     = 480;
    localparam int H_TOTAL      = 800;
    localparam int V_TOTAL      = 525;
    localparam int PIX_W        = 4;
    localparam int PIX_PER_WORD = 4;
    localparam int DATA_W       = PIX_W * PIX_PER_WORD;
    localparam int ADDR_W       = 17;
    localparam int FB_WORDS     = H_ACTIVE * V_ACTIVE / PIX_PER_WORD;
    localparam int SUB_W        = $clog2(PIX_PER_WORD);

    typedef enum logic [1:0] {
        GNT_NONE  = 2'd0,
        GNT_READ  = 2'd1,
        GNT_WRITE = 2'd2
    } grant_e;
endpackage

// File: rtl/vga_word_fifo.sv
// Two-entry prefetch buffer for packed pixel words.
// Push and pop may happen in the same cycle. Flush empties the buffer and wins over both.
module vga_word_fifo
    import vga_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] head,
    output logic              empty,
    output logic              full,
    output logic [1:0]        count
);
    logic [DATA_W-1:0] mem_r [2];
    logic              rd_ptr_r;
    logic              wr_ptr_r;
    logic [1:0]        count_r;
    logic              push_ok_s;
    logic              pop_ok_s;

    // Qualify requests against the current occupancy
    always_comb begin
        pop_ok_s  = pop && (count_r != 2'd0);
        push_ok_s = push && ((count_r != 2'd2) || pop_ok_s);
    end

    // Storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            mem_r[0] <= '0;
            mem_r[1] <= '0;
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign empty = (count_r == 2'd0);
    assign full  = (count_r == 2'd2);
    assign count = count_r;
endmodule

// File: rtl/vga_vram_arbiter.sv
// Shares one single-port video RAM between display prefetch and a writer port.
// It also unpacks the prefetched words into one registered pixel per active cycle.
module vga_vram_arbiter
    import vga_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              disp_active_i,
    input  logic [9:0]        xcol_i,
    input  logic [9:0]        yrow_i,
    input  logic              wr_req_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              wr_ack_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [PIX_W-1:0]  pixel_o,
    output logic              pixel_valid_o,
    output logic              underrun_o
);
    localparam logic [9:0]       RESTART_ROW = 10'(V_ACTIVE);
    localparam logic [SUB_W-1:0] SUB_LAST    = SUB_W'(PIX_PER_WORD - 1);

    logic              mem_en_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              wr_ack_r;
    logic [PIX_W-1:0]  pixel_r;
    logic              pixel_valid_r;
    logic              underrun_r;
    logic [ADDR_W-1:0] rd_word_r;
    logic [SUB_W-1:0]  sub_r;
    logic              rd_pend1_r;
    logic              rd_pend2_r;
    logic              rd_disc2_r;

    grant_e            grant_s;
    logic              restart_s;
    logic [2:0]        credits_s;
    logic              credit_ok_s;
    logic              words_left_s;
    logic              push_s;
    logic              pop_s;
    logic              advance_s;
    logic              underrun_set_s;
    logic [PIX_W-1:0]  pixel_next_s;
    logic [DATA_W-1:0] fifo_head_s;
    logic              fifo_empty_s;
    logic              fifo_full_s;
    logic [1:0]        fifo_count_s;

    assign restart_s    = (xcol_i == 10'd0) && (yrow_i == RESTART_ROW);
    // Occupancy plus both stages of read latency may never exceed the two buffer slots
    assign credits_s    = 3'(fifo_count_s) + 3'(rd_pend1_r) + 3'(rd_pend2_r);
    assign credit_ok_s  = !fifo_full_s && (credits_s < 3'd2);
    assign words_left_s = (rd_word_r < ADDR_W'(FB_WORDS));
    assign push_s       = rd_pend2_r && !rd_disc2_r && !restart_s;

    // RAM slot arbitration: display prefetch first, then the writer
    always_comb begin
        grant_s = GNT_NONE;
        if (restart_s) begin
            grant_s = GNT_NONE;
        end else if (credit_ok_s && words_left_s) begin
            grant_s = GNT_READ;
        end else if (wr_req_i && !wr_ack_r) begin
            grant_s = GNT_WRITE;
        end else begin
            grant_s = GNT_NONE;
        end
    end

    // Pixel selection from the head word and buffer consumption
    always_comb begin
        pixel_next_s   = '0;
        pop_s          = 1'b0;
        advance_s      = 1'b0;
        underrun_set_s = 1'b0;
        if (restart_s) begin
            pixel_next_s = '0;
        end else if (disp_active_i && !fifo_empty_s) begin
            pixel_next_s = fifo_head_s[sub_r*PIX_W +: PIX_W];
            advance_s    = 1'b1;
            pop_s        = (sub_r == SUB_LAST);
        end else if (disp_active_i) begin
            underrun_set_s = 1'b1;
        end else begin
            pixel_next_s = '0;
        end
    end

    // Registered RAM port, read tracking and pixel outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_en_r      <= 1'b0;
            mem_we_r      <= 1'b0;
            mem_addr_r    <= '0;
            mem_wdata_r   <= '0;
            wr_ack_r      <= 1'b0;
            rd_pend1_r    <= 1'b0;
            rd_pend2_r    <= 1'b0;
            rd_disc2_r    <= 1'b0;
            rd_word_r     <= '0;
            sub_r         <= '0;
            pixel_r       <= '0;
            pixel_valid_r <= 1'b0;
            underrun_r    <= 1'b0;
        end else begin
            case (grant_s)
                GNT_READ: begin
                    mem_en_r   <= 1'b1;
                    mem_we_r   <= 1'b0;
                    mem_addr_r <= rd_word_r;
                    wr_ack_r   <= 1'b0;
                end
                GNT_WRITE: begin
                    mem_en_r    <= 1'b1;
                    mem_we_r    <= 1'b1;
                    mem_addr_r  <= wr_addr_i;
                    mem_wdata_r <= wr_data_i;
                    wr_ack_r    <= 1'b1;
                end
                default: begin
                    mem_en_r <= 1'b0;
                    mem_we_r <= 1'b0;
                    wr_ack_r <= 1'b0;
                end
            endcase
            rd_pend1_r <= (grant_s == GNT_READ);
            rd_pend2_r <= rd_pend1_r;
            // A read already on the RAM port at restart returns stale data next cycle
            rd_disc2_r <= restart_s;
            if (restart_s) begin
                rd_word_r <= '0;
                sub_r     <= '0;
            end else begin
                if (grant_s == GNT_READ) begin
                    rd_word_r <= rd_word_r + ADDR_W'(1);
                end
                if (advance_s) begin
                    sub_r <= (sub_r == SUB_LAST) ? '0 : sub_r + SUB_W'(1);
                end
            end
            pixel_r       <= pixel_next_s;
            pixel_valid_r <= disp_active_i;
            underrun_r    <= underrun_r | underrun_set_s;
        end
    end

    vga_word_fifo u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push_s),
        .pop   (pop_s),
        .flush (restart_s),
        .wdata (mem_rdata_i),
        .head  (fifo_head_s),
        .empty (fifo_empty_s),
        .full  (fifo_full_s),
        .count (fifo_count_s)
    );

    assign mem_en_o      = mem_en_r;
    assign mem_we_o      = mem_we_r;
    assign mem_addr_o    = mem_addr_r;
    assign mem_wdata_o   = mem_wdata_r;
    assign wr_ack_o      = wr_ack_r;
    assign pixel_o       = pixel_r;
    assign pixel_valid_o = pixel_valid_r;
    assign underrun_o    = underrun_r;
endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Directed bench for vga_vram_arbiter with a behavioural one-cycle-latency RAM.
// A vector table covers prefetch and scan-out; hand sequences cover writes, restart and underrun.
module tb_vga_vram_arbiter;
    import vga_pkg::*;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              disp_active_i;
    logic [9:0]        xcol_i;
    logic [9:0]        yrow_i;
    logic              wr_req_i;
    logic [ADDR_W-1:0] wr_addr_i;
    logic [DATA_W-1:0] wr_data_i;
    logic              wr_ack_o;
    logic              mem_en_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic [PIX_W-1:0]  pixel_o;
    logic              pixel_valid_o;
    logic              underrun_o;

    int checks = 0;
    int errors = 0;

    logic [15:0] ram [0:131071];

    typedef struct {
        logic        act;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        wreq;
        logic        en;
        logic        we;
        logic [16:0] addr;
        logic [15:0] wdata;
        logic        ack;
        logic [3:0]  pix;
        logic        pv;
    } vec_t;

    vec_t vt [14];

    always #20 clk_i = ~clk_i;

    vga_vram_arbiter dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .disp_active_i (disp_active_i),
        .xcol_i        (xcol_i),
        .yrow_i        (yrow_i),
        .wr_req_i      (wr_req_i),
        .wr_addr_i     (wr_addr_i),
        .wr_data_i     (wr_data_i),
        .wr_ack_o      (wr_ack_o),
        .mem_en_o      (mem_en_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_rdata_i   (mem_rdata_i),
        .pixel_o       (pixel_o),
        .pixel_valid_o (pixel_valid_o),
        .underrun_o    (underrun_o)
    );

    // Single-port synchronous RAM: read data appears the cycle after the request
    always @(posedge clk_i) begin
        if (mem_en_o && mem_we_o) begin
            ram[mem_addr_o] <= mem_wdata_o;
        end else if (mem_en_o) begin
            mem_rdata_i <= ram[mem_addr_o];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input logic act, input logic [9:0] x, input logic [9:0] y, input logic wreq);
        disp_active_i = act;
        xcol_i        = x;
        yrow_i        = y;
        wr_req_i      = wreq;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick(1'b0, 10'd700, 10'd0, 1'b0);
        tick(1'b0, 10'd700, 10'd0, 1'b0);
        rst_i = 1'b0;
    endtask

    initial begin
        int acks;
        int reads;
        logic prev_ack;

        for (int i = 0; i < 131072; i++) ram[i] = 16'h0000;
        ram[0] = 16'h4321;
        ram[1] = 16'h8765;
        ram[2] = 16'hCBA9;
        ram[3] = 16'h0FED;
        mem_rdata_i = 16'h0000;
        wr_addr_i   = 17'h00100;
        wr_data_i   = 16'hABCD;

        //            act   x        y      wreq  en    we    addr      wdata     ack   pix   pv
        vt[0]  = '{1'b0, 10'd700, 10'd0, 1'b0, 1'b1, 1'b0, 17'h0,    16'h0,    1'b0, 4'd0, 1'b0};
        vt[1]  = '{1'b0, 10'd701, 10'd0, 1'b0, 1'b1, 1'b0, 17'h1,    16'h0,    1'b0, 4'd0, 1'b0};
        vt[2]  = '{1'b0, 10'd702, 10'd0, 1'b0, 1'b0, 1'b0, 17'h0,    16'h0,    1'b0, 4'd0, 1'b0};
        vt[3]  = '{1'b0, 10'd703, 10'd0, 1'b0, 1'b0, 1'b0, 17'h0,    16'h0,    1'b0, 4'd0, 1'b0};
        vt[4]  = '{1'b0, 10'd704, 10'd0, 1'b0, 1'b0, 1'b0, 17'h0,    16'h0,    1'b0, 4'd0, 1'b0};
        vt[5]  = '{1'b1, 10'd0,   10'd0, 1'b0, 1'b0, 1'b0, 17'h0,    16'h0,    1'b0, 4'd1, 1'b1};
        vt[6]  = '{1'b1, 10'd1,   10'd0, 1'b0, 1'b0, 1'b0, 17'h0,    16'h0,    1'b0, 4'd2, 1'b1};
        vt[7]  = '{1'b1, 10'd2,   10'd0, 1'b0, 1'b0, 1'b0, 17'h0,    16'h0,    1'b0, 4'd3, 1'b1};
        vt[8]  = '{1'b1, 10'd3,   10'd0, 1'b0, 1'b0, 1'b0, 17'h0,    16'h0,    1'b0, 4'd4, 1'b1};
        vt[9]  = '{1'b1, 10'd4,   10'd0, 1'b1, 1'b1, 1'b0, 17'h2,    16'h0,    1'b0, 4'd5, 1'b1};
        vt[10] = '{1'b1, 10'd5,   10'd0, 1'b1, 1'b1, 1'b1, 17'h100,  16'hABCD, 1'b1, 4'd6, 1'b1};
        vt[11] = '{1'b1, 10'd6,   10'd0, 1'b0, 1'b0, 1'b0, 17'h0,    16'h0,    1'b0, 4'd7, 1'b1};
        vt[12] = '{1'b1, 10'd7,   10'd0, 1'b0, 1'b0, 1'b0, 17'h0,    16'h0,    1'b0, 4'd8, 1'b1};
        vt[13] = '{1'b1, 10'd8,   10'd0, 1'b0, 1'b1, 1'b0, 17'h3,    16'h0,    1'b0, 4'd9, 1'b1};

        // Reset state
        disp_active_i = 1'b0;
        xcol_i        = 10'd700;
        yrow_i        = 10'd0;
        wr_req_i      = 1'b0;
        do_reset();
        chk("rst_en",       32'(mem_en_o),      32'd0);
        chk("rst_we",       32'(mem_we_o),      32'd0);
        chk("rst_addr",     32'(mem_addr_o),    32'd0);
        chk("rst_wdata",    32'(mem_wdata_o),   32'd0);
        chk("rst_ack",      32'(wr_ack_o),      32'd0);
        chk("rst_pixel",    32'(pixel_o),       32'd0);
        chk("rst_valid",    32'(pixel_valid_o), 32'd0);
        chk("rst_underrun", 32'(underrun_o),    32'd0);

        // Prefetch, scan-out and a writer request colliding with a due read
        for (int i = 0; i < 14; i++) begin
            tick(vt[i].act, vt[i].x, vt[i].y, vt[i].wreq);
            chk($sformatf("v%0d_en", i),  32'(mem_en_o),      32'(vt[i].en));
            chk($sformatf("v%0d_we", i),  32'(mem_we_o),      32'(vt[i].we));
            chk($sformatf("v%0d_ack", i), 32'(wr_ack_o),      32'(vt[i].ack));
            chk($sformatf("v%0d_pix", i), 32'(pixel_o),       32'(vt[i].pix));
            chk($sformatf("v%0d_pv", i),  32'(pixel_valid_o), 32'(vt[i].pv));
            chk($sformatf("v%0d_und", i), 32'(underrun_o),    32'd0);
            if (vt[i].en) chk($sformatf("v%0d_addr", i), 32'(mem_addr_o), 32'(vt[i].addr));
            if (vt[i].we) chk($sformatf("v%0d_wdata", i), 32'(mem_wdata_o), 32'(vt[i].wdata));
        end

        // Held write request during blanking with a full buffer: one ack per two cycles
        wr_addr_i = 17'h12345;
        wr_data_i = 16'h5A5A;
        acks      = 0;
        reads     = 0;
        prev_ack  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 10'(650 + i), 10'd0, 1'b1);
            if (wr_ack_o) begin
                acks++;
                chk("burst_we",    32'(mem_we_o && mem_en_o), 32'd1);
                chk("burst_addr",  32'(mem_addr_o),  32'h12345);
                chk("burst_wdata", 32'(mem_wdata_o), 32'h5A5A);
                chk("burst_b2b",   32'(prev_ack),    32'd0);
            end
            if (mem_en_o && !mem_we_o) reads++;
            prev_ack = wr_ack_o;
        end
        chk("burst_ack_count",  32'(acks),  32'd5);
        chk("burst_read_count", 32'(reads), 32'd0);

        // Frame restart while two reads are in flight
        do_reset();
        tick(1'b0, 10'd700, 10'd0, 1'b0);
        tick(1'b0, 10'd701, 10'd0, 1'b0);
        tick(1'b0, 10'd0, 10'd480, 1'b0);
        chk("restart_en_idle", 32'(mem_en_o), 32'd0);
        tick(1'b0, 10'd1, 10'd480, 1'b0);
        chk("restart_rd0_en",   32'(mem_en_o && !mem_we_o), 32'd1);
        chk("restart_rd0_addr", 32'(mem_addr_o), 32'd0);
        tick(1'b0, 10'd2, 10'd480, 1'b0);
        chk("restart_rd1_en",   32'(mem_en_o && !mem_we_o), 32'd1);
        chk("restart_rd1_addr", 32'(mem_addr_o), 32'd1);
        for (int i = 0; i < 4; i++) tick(1'b0, 10'(3 + i), 10'd480, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 10'(i), 10'd0, 1'b0);
            chk($sformatf("restart_pix%0d", i), 32'(pixel_o), 32'(i + 1));
        end
        chk("restart_underrun", 32'(underrun_o), 32'd0);

        // Display starts before any data has returned
        do_reset();
        tick(1'b0, 10'd799, 10'd524, 1'b0);
        chk("und_before", 32'(underrun_o), 32'd0);
        tick(1'b1, 10'd0, 10'd0, 1'b0);
        chk("und_pixel", 32'(pixel_o),       32'd0);
        chk("und_valid", 32'(pixel_valid_o), 32'd1);
        chk("und_set",   32'(underrun_o),    32'd1);
        for (int i = 1; i < 4; i++) begin
            tick(1'b1, 10'(i), 10'd0, 1'b0);
            chk($sformatf("und_sticky%0d", i), 32'(underrun_o), 32'd1);
        end
        tick(1'b0, 10'd700, 10'd0, 1'b0);
        chk("und_sticky_blank", 32'(underrun_o), 32'd1);
        rst_i = 1'b1;
        tick(1'b0, 10'd700, 10'd0, 1'b0);
        chk("und_cleared", 32'(underrun_o), 32'd0);
        rst_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
